// File: rtl/jam_cost_server.sv
// jam_cost_server: 8x8 worker/job cost table with streaming load, W/J lookup and result capture.
// Define JAM_COST_REG_EN for a registered Cost read (one-cycle latency).
module jam_cost_server #(
    parameter int LCNT_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              clear,
    input  logic              load_en,
    input  logic [6:0]        load_data,
    output logic              load_ready,
    input  logic [2:0]        W,
    input  logic [2:0]        J,
    output logic [6:0]        Cost,
    input  logic              Valid,
    input  logic [9:0]        MinCost,
    input  logic [3:0]        MatchCount,
    output logic              serving,
    output logic              done,
    output logic [9:0]        res_min_cost,
    output logic [3:0]        res_match_count,
    output logic [LCNT_W-1:0] lookup_cnt
);
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, SERVE = 2'd2, DONE = 2'd3;
    logic [1:0]        state_q, state_d;
    logic [5:0]        addr_q, addr_d;
    logic              done_q, done_d;
    logic [9:0]        res_min_cost_q, res_min_cost_d;
    logic [3:0]        res_match_count_q, res_match_count_d;
    logic [LCNT_W-1:0] lookup_cnt_q, lookup_cnt_d;
    logic [6:0]        mem_q [64];
    logic [6:0]        rd;
    logic              we, capture;
    always_comb begin
        we                = !clear && load_en && (state_q == IDLE || state_q == LOAD);
        capture           = !clear && Valid && state_q == SERVE;
        state_d           = clear ? IDLE : (we && addr_q == 6'd63) ? SERVE : we ? LOAD : capture ? DONE : state_q;
        addr_d            = clear ? 6'd0 : we ? addr_q + 6'd1 : addr_q;
        done_d            = capture;
        res_min_cost_d    = clear ? 10'd0 : capture ? MinCost : res_min_cost_q;
        res_match_count_d = clear ? 4'd0 : capture ? MatchCount : res_match_count_q;
        lookup_cnt_d      = clear ? '0
                          : (state_q == SERVE && !Valid && !(&lookup_cnt_q)) ? lookup_cnt_q + {{(LCNT_W-1){1'b0}}, 1'b1}
                          : lookup_cnt_q;
        rd                = mem_q[{W, J}];
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q           <= IDLE;
            addr_q            <= 6'd0;
            done_q            <= 1'b0;
            res_min_cost_q    <= 10'd0;
            res_match_count_q <= 4'd0;
            lookup_cnt_q      <= '0;
        end else begin
            state_q           <= state_d;
            addr_q            <= addr_d;
            done_q            <= done_d;
            res_min_cost_q    <= res_min_cost_d;
            res_match_count_q <= res_match_count_d;
            lookup_cnt_q      <= lookup_cnt_d;
        end
    end
    // Table storage has no reset; Cost gating keeps stale entries hidden.
    always_ff @(posedge CLK) begin
        if (we) mem_q[addr_q] <= load_data;
    end
`ifdef JAM_COST_REG_EN
    logic [6:0] cost_q, cost_d;
    always_comb begin
        cost_d = (state_q == SERVE && state_d == SERVE) ? rd : 7'd0;
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) cost_q <= 7'd0;
        else     cost_q <= cost_d;
    end
    assign Cost = cost_q;
`else
    assign Cost = (state_q == SERVE) ? rd : 7'd0;
`endif
    assign load_ready      = state_q == IDLE || state_q == LOAD;
    assign serving         = state_q == SERVE;
    assign done            = done_q;
    assign res_min_cost    = res_min_cost_q;
    assign res_match_count = res_match_count_q;
    assign lookup_cnt      = lookup_cnt_q;
endmodule

// File: tb/tb_jam_cost_server.sv
// tb_jam_cost_server: scoreboard bench; stimulus queues expectations, negedge monitors compare.
module tb_jam_cost_server;
    logic        CLK = 1'b0, RST = 1'b1, clear = 1'b0, load_en = 1'b0, Valid = 1'b0;
    logic [6:0]  load_data = 7'd0;
    logic [2:0]  W = 3'd0, J = 3'd0;
    logic [9:0]  MinCost = 10'd0;
    logic [3:0]  MatchCount = 4'd0;
    logic        load_ready, serving, done, load_ready2, serving2, done2;
    logic [6:0]  Cost, Cost2;
    logic [9:0]  res_min_cost, res_min_cost2;
    logic [3:0]  res_match_count, res_match_count2, lookup_cnt2;
    logic [15:0] lookup_cnt;

    typedef struct {int sel; int idx; int exp; string name;} exp_t;
    exp_t chk_q[$];
    int   done_q[$];
    int   n_tests = 0, n_fail = 0, n_done = 0;
    logic probe = 1'b0;

    always #5 CLK = ~CLK;

    jam_cost_server dut (
        .CLK(CLK), .RST(RST), .clear(clear), .load_en(load_en), .load_data(load_data),
        .load_ready(load_ready), .W(W), .J(J), .Cost(Cost), .Valid(Valid), .MinCost(MinCost),
        .MatchCount(MatchCount), .serving(serving), .done(done), .res_min_cost(res_min_cost),
        .res_match_count(res_match_count), .lookup_cnt(lookup_cnt));

    jam_cost_server #(.LCNT_W(4)) dut2 (
        .CLK(CLK), .RST(RST), .clear(clear), .load_en(load_en), .load_data(load_data),
        .load_ready(load_ready2), .W(W), .J(J), .Cost(Cost2), .Valid(Valid), .MinCost(MinCost),
        .MatchCount(MatchCount), .serving(serving2), .done(done2), .res_min_cost(res_min_cost2),
        .res_match_count(res_match_count2), .lookup_cnt(lookup_cnt2));

    function automatic int get(int sel, int idx);
        case (sel)
            0: return int'(Cost);
            1: return int'(load_ready);
            2: return int'(serving);
            3: return int'(done);
            4: return int'(res_min_cost);
            5: return int'(res_match_count);
            6: return int'(lookup_cnt);
            7: return int'(lookup_cnt2);
            8: return int'(dut.mem_q[idx[5:0]]);
            9: return int'(dut.addr_q);
            10: return int'(dut.state_q);
            default: return -1;
        endcase
    endfunction

    always @(negedge CLK) begin : mon
        exp_t e;
        int   a;
        if (probe) begin
            while (chk_q.size() > 0) begin
                e = chk_q.pop_front();
                a = get(e.sel, e.idx);
                n_tests++;
                if (a != e.exp) begin
                    n_fail++;
                    $display("FAIL %s got=%0d want=%0d", e.name, a, e.exp);
                end
            end
        end
    end

    always @(negedge CLK) begin : dmon
        int e;
        if (done) begin
            n_done++;
            n_tests++;
            if (done_q.size() == 0) begin
                n_fail++;
                $display("FAIL done_unexpected got=%0d/%0d want=no_done", res_min_cost, res_match_count);
            end else begin
                e = done_q.pop_front();
                if (e != int'(res_min_cost) * 16 + int'(res_match_count)) begin
                    n_fail++;
                    $display("FAIL done_capture got=%0d/%0d want=%0d/%0d",
                             res_min_cost, res_match_count, e / 16, e % 16);
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(int sel, int exp, string name, int idx = 0);
        chk_q.push_back('{sel, idx, exp, name});
    endtask

    task automatic flush();
        probe = 1'b1;
        @(negedge CLK);
        #1;
        probe = 1'b0;
    endtask

    task automatic beat(int d);
        load_en   = 1'b1;
        load_data = 7'(d);
        step();
        load_en   = 1'b0;
    endtask

    task automatic look(int w, int j, int exp, string name);
        W = 3'(w);
        J = 3'(j);
`ifdef JAM_COST_REG_EN
        step();
`endif
        chk(0, exp, name);
        flush();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk(0, 0, "rst_cost"); chk(1, 1, "rst_load_ready"); chk(2, 0, "rst_serving");
        chk(3, 0, "rst_done"); chk(4, 0, "rst_min"); chk(5, 0, "rst_mc"); chk(6, 0, "rst_lcnt");
        chk(9, 0, "rst_addr"); chk(10, 0, "rst_state");
        flush();
        RST = 1'b0;
        step();
        // full load with addr%100
        W = 3'd3; J = 3'd5;
        for (int a = 0; a < 64; a++) begin
            beat(a % 100);
            if (a == 40) begin chk(0, 0, "cost_during_load"); chk(1, 1, "lr_during_load"); flush(); end
        end
        chk(1, 0, "lr_after_64"); chk(2, 1, "serving_after_64");
`ifdef JAM_COST_REG_EN
        chk(0, 0, "cost_first_serve_reg");
`endif
        flush();
        look(3, 5, 29, "cost_3_5");
        look(7, 7, 63, "cost_7_7");
        look(1, 2, 10, "cost_1_2");
        clear = 1'b1; step(); clear = 1'b0;
        chk(6, 0, "clr_lcnt"); chk(2, 0, "clr_serving"); chk(1, 1, "clr_lr"); chk(10, 0, "clr_state");
        flush();
        // Valid during load, then clear together with load_en at address 10
        Valid = 1'b1; MinCost = 10'd99; MatchCount = 4'd9;
        for (int a = 0; a < 10; a++) beat(50);
        clear = 1'b1; load_en = 1'b1; load_data = 7'd99;
        step();
        clear = 1'b0; load_en = 1'b0;
        chk(10, 0, "clrld_state"); chk(9, 0, "clrld_addr"); chk(8, 10, "clrld_entry10", 10);
        chk(8, 50, "clrld_entry9", 9); chk(3, 0, "clrld_done");
        flush();
        done_q.push_back(123 * 16 + 5);
        for (int a = 0; a < 64; a++) beat(a + 1);
        MinCost = 10'd123; MatchCount = 4'd5;
        chk(2, 1, "reload_serving"); chk(8, 1, "reload_entry0", 0); chk(8, 11, "reload_entry10", 10);
        chk(8, 64, "reload_entry63", 63); chk(3, 0, "no_done_in_load");
        flush();
        step();
        chk(3, 1, "first_serve_done"); chk(4, 123, "first_serve_min"); chk(5, 5, "first_serve_mc");
        chk(6, 0, "first_serve_lcnt"); chk(0, 0, "cost_in_done"); chk(2, 0, "serving_in_done");
        flush();
        step();
        chk(3, 0, "done_drops");
        flush();
        // reset mid-load
        Valid = 1'b0;
        clear = 1'b1; step(); clear = 1'b0;
        for (int a = 0; a < 30; a++) beat(3);
        RST = 1'b1; #2; RST = 1'b0;
        chk(9, 0, "midrst_addr"); chk(10, 0, "midrst_state"); chk(1, 1, "midrst_lr");
        flush();
        W = 3'd3; J = 3'd5;
        for (int a = 0; a < 64; a++) begin
            beat(7);
            if (a == 20) begin chk(0, 0, "cost_during_reload"); flush(); end
        end
        for (int w = 0; w < 8; w++)
            for (int j = 0; j < 8; j++) look(w, j, 7, $sformatf("cost7_w%0d_j%0d", w, j));
        // lookup counting and capture
        clear = 1'b1; step(); clear = 1'b0;
        for (int a = 0; a < 64; a++) beat(7);
        for (int i = 1; i <= 100; i++) begin
            step();
            if (i == 20) begin chk(6, 20, "lcnt_20"); chk(7, 15, "lcnt4_sat"); flush(); end
        end
        Valid = 1'b1; MinCost = 10'd300; MatchCount = 4'd2;
        done_q.push_back(300 * 16 + 2);
        step();
        chk(3, 1, "cap_done"); chk(4, 300, "cap_min"); chk(5, 2, "cap_mc");
        chk(6, 100, "cap_lcnt"); chk(7, 15, "cap_lcnt4");
        flush();
        MinCost = 10'd500; MatchCount = 4'd7;
        for (int i = 0; i < 3; i++) step();
        chk(3, 0, "hold_done"); chk(4, 300, "hold_min"); chk(5, 2, "hold_mc"); chk(6, 100, "hold_lcnt");
        flush();
        Valid = 1'b0;
        n_tests++;
        if (n_done != 2 || done_q.size() != 0) begin
            n_fail++;
            $display("FAIL done_count got=%0d pending=%0d want=2 pending=0", n_done, done_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
